// File: rtl/sa_input_skewer.sv
`timescale 1ns/1ps
// sa_input_skewer: per-lane delay chains that turn row-aligned vectors into the
// diagonal wavefront SA_CORE consumes, then zero-flush the tail and pulse done.
module sa_input_skewer #(
    parameter int ROWS = 8,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ROWS*DW-1:0] in_a,
    input  logic [ROWS*DW-1:0] in_w,
    input  logic               in_last,
    output logic [ROWS*DW-1:0] core_a,
    output logic [ROWS*DW-1:0] core_w,
    output logic               core_valid,
    output logic               done
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // The flush counter only has to reach ROWS-2, the index of the final zero advance.
    localparam int            CW       = (ROWS > 2) ? $clog2(ROWS - 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((ROWS > 1) ? ROWS - 2 : 0);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          take;
    logic          adv;
    logic          flush_end;

    assign in_ready  = (state == RUN);
    assign take      = in_ready & in_valid;
    assign adv       = take | (state == FLUSH);
    assign flush_end = (state == FLUSH) && (cnt == CNT_LAST);

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would let the shift chains collapse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= RUN;
            cnt        <= '0;
            core_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            core_valid <= adv;
            done       <= 1'b0;
            case (state)
                RUN: begin
                    if (take && in_last) begin
                        if (ROWS > 1) begin
                            state <= FLUSH;
                            cnt   <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    cnt <= cnt + CW'(1);
                    if (flush_end) begin
                        state <= RUN;
                        done  <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Lane r is a chain of r+1 registers; its last stage drives the output lane.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [DW-1:0] a_sr [r+1];
        logic [DW-1:0] w_sr [r+1];

        // NOTE: the chains are reset, unlike a plain storage array, because their
        // last stages are the module outputs and a reset must drop partial wavefronts.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int i = 0; i <= r; i++) begin
                    a_sr[i] <= '0;
                    w_sr[i] <= '0;
                end
            end else if (adv) begin
                a_sr[0] <= (state == FLUSH) ? '0 : in_a[r*DW +: DW];
                w_sr[0] <= (state == FLUSH) ? '0 : in_w[r*DW +: DW];
                for (int i = 1; i <= r; i++) begin
                    a_sr[i] <= a_sr[i-1];
                    w_sr[i] <= w_sr[i-1];
                end
            end
        end

        assign core_a[r*DW +: DW] = a_sr[r];
        assign core_w[r*DW +: DW] = w_sr[r];
    end

endmodule

// File: tb/tb_sa_input_skewer.sv
`timescale 1ns/1ps
// Bench for sa_input_skewer: a table of streams drives the DUT while a scoreboard,
// built from the ideal wavefront of each stream, is popped on every core_valid.
module tb_sa_input_skewer;

    localparam int ROWS = 8;
    localparam int DW   = 8;
    localparam int W    = ROWS * DW;

    logic         clk = 1'b0;
    logic         rstn;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_w;
    logic         in_last;
    logic [W-1:0] core_a;
    logic [W-1:0] core_w;
    logic         core_valid;
    logic         done;

    sa_input_skewer #(.ROWS(ROWS), .DW(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_w       (in_w),
        .in_last    (in_last),
        .core_a     (core_a),
        .core_w     (core_w),
        .core_valid (core_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] w;
        logic         done;
    } exp_t;

    typedef struct {
        int n;
        int pat;
        bit bubble;
        bit hold_next;
        bit chain;
        int exp_valid;
        int exp_done;
    } stream_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           vectors     = 0;
    int           miscompares = 0;
    int           valid_cnt   = 0;
    int           done_cnt    = 0;
    bit           mon_en      = 1'b0;
    bit           nogap_chk   = 1'b0;
    bit           nogap_arm   = 1'b0;
    logic [W-1:0] last_a      = '0;
    logic [W-1:0] last_w      = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pat_a(input int p, input int i, input int r);
        case (p)
            0:       return DW'(5);
            1:       return DW'(i);
            2:       return DW'(32'hA0 + i * 7 + r * 3);
            default: return DW'(32'h30 + i * 5 + r * 13);
        endcase
    endfunction

    function automatic logic [DW-1:0] pat_w(input int p, input int i, input int r);
        case (p)
            0:       return DW'(1);
            1:       return DW'(32'h80 | i);
            2:       return DW'(32'h11 + i * 3 + r);
            default: return DW'(32'hC0 ^ (i * 9 + r));
        endcase
    endfunction

    task automatic drive_vec(input int p, input int i);
        for (int r = 0; r < ROWS; r++) begin
            in_a[r*DW +: DW] = pat_a(p, i, r);
            in_w[r*DW +: DW] = pat_w(p, i, r);
        end
    endtask

    // Output j, lane r carries input vector j-r; anything outside the stream is a flush zero.
    task automatic send_stream(input int n, input int p, input bit bubble, input int hold_p);
        exp_t e;
        int   i;
        int   cyc;
        bit   ph;
        for (int j = 0; j < n + ROWS - 1; j++) begin
            e.a = '0;
            e.w = '0;
            for (int r = 0; r < ROWS; r++) begin
                if (j - r >= 0 && j - r < n) begin
                    e.a[r*DW +: DW] = pat_a(p, j - r, r);
                    e.w[r*DW +: DW] = pat_w(p, j - r, r);
                end
            end
            e.done = (j == n + ROWS - 2);
            sb.push_back(e);
        end
        i   = 0;
        cyc = 0;
        ph  = 1'b0;
        while (i < n) begin
            if (bubble && ph) begin
                in_valid = 1'b0;
                in_a     = {$urandom, $urandom};
                in_w     = {$urandom, $urandom};
                in_last  = 1'b1;
            end else begin
                in_valid = 1'b1;
                drive_vec(p, i);
                in_last  = (i == n - 1);
            end
            ph = !ph;
            check("in_ready_run", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            if (in_valid) i++;
            cyc++;
            if (cyc > 200) begin
                check("stream_accept_budget", 64'(i), 64'(n));
                break;
            end
        end
        for (int k = 0; k < ROWS - 1; k++) begin
            if (hold_p >= 0) begin
                in_valid = 1'b1;
                drive_vec(hold_p, 0);
                in_last  = 1'b1;
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            check("in_ready_flush", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (nogap_arm) check("nogap_after_done", 64'(core_valid), 64'd1);
            nogap_arm = nogap_chk && core_valid && done;
            if (core_valid) begin
                valid_cnt++;
                if (done) done_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_core_valid", 64'(core_valid), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("core_a", core_a, mon_e.a);
                    check("core_w", core_w, mon_e.w);
                    check("done", 64'(done), 64'(mon_e.done));
                end
                last_a = core_a;
                last_w = core_w;
            end else begin
                check("hold_core_a", core_a, last_a);
                check("hold_core_w", core_w, last_w);
                check("done_without_valid", 64'(done), 64'd0);
            end
        end
    end

    initial begin
        stream_t tbl[7];
        int      gv;
        int      gd;
        int      hp;

        // Chained records share the counts of the record that ends the group.
        tbl[0] = '{n: 1,  pat: 0, bubble: 1'b0, hold_next: 1'b0, chain: 1'b0, exp_valid: 8,  exp_done: 1};
        tbl[1] = '{n: 16, pat: 1, bubble: 1'b0, hold_next: 1'b0, chain: 1'b0, exp_valid: 23, exp_done: 1};
        tbl[2] = '{n: 16, pat: 1, bubble: 1'b1, hold_next: 1'b0, chain: 1'b0, exp_valid: 23, exp_done: 1};
        tbl[3] = '{n: 5,  pat: 2, bubble: 1'b0, hold_next: 1'b1, chain: 1'b1, exp_valid: 0,  exp_done: 0};
        tbl[4] = '{n: 6,  pat: 3, bubble: 1'b0, hold_next: 1'b0, chain: 1'b0, exp_valid: 25, exp_done: 2};
        tbl[5] = '{n: 3,  pat: 2, bubble: 1'b0, hold_next: 1'b0, chain: 1'b1, exp_valid: 0,  exp_done: 0};
        tbl[6] = '{n: 4,  pat: 1, bubble: 1'b0, hold_next: 1'b0, chain: 1'b0, exp_valid: 21, exp_done: 2};

        rstn     = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a     = '0;
        in_w     = '0;
        #1;
        check("reset_core_a", core_a, 64'd0);
        check("reset_core_w", core_w, 64'd0);
        check("reset_core_valid", 64'(core_valid), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        check("in_ready_after_reset", 64'(in_ready), 64'd1);
        mon_en = 1'b1;

        gv = 0;
        gd = 0;
        for (int t = 0; t < 7; t++) begin
            hp = (t < 6 && tbl[t].hold_next) ? tbl[t+1].pat : -1;
            send_stream(tbl[t].n, tbl[t].pat, tbl[t].bubble, hp);
            nogap_chk = tbl[t].chain;
            if (!tbl[t].chain) begin
                drain();
                check("core_valid_count", 64'(valid_cnt - gv), 64'(tbl[t].exp_valid));
                check("done_count", 64'(done_cnt - gd), 64'(tbl[t].exp_done));
                gv = valid_cnt;
                gd = done_cnt;
            end
        end

        // Reset while flushing a partial stream: outputs clear at once, no done follows.
        mon_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            drive_vec(2, i);
            in_last  = (i == 2);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_before_reset", 64'(in_ready), 64'd0);
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset_core_a", core_a, 64'd0);
        check("async_reset_core_w", core_w, 64'd0);
        check("async_reset_core_valid", 64'(core_valid), 64'd0);
        check("async_reset_done", 64'(done), 64'd0);
        check("async_reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        check("in_ready_after_midreset", 64'(in_ready), 64'd1);
        sb.delete();
        last_a    = '0;
        last_w    = '0;
        nogap_arm = 1'b0;
        nogap_chk = 1'b0;
        gv        = valid_cnt;
        gd        = done_cnt;
        mon_en    = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("no_valid_after_midreset", 64'(valid_cnt - gv), 64'd0);
        check("no_done_after_midreset", 64'(done_cnt - gd), 64'd0);

        send_stream(2, 3, 1'b0, -1);
        drain();
        check("core_valid_count_post_reset", 64'(valid_cnt - gv), 64'd9);
        check("done_count_post_reset", 64'(done_cnt - gd), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
